// File: rtl/qspi_bus_arbiter.sv
// Round-robin arbiter sharing one QSPI pad group among NUM_CH masters, with a guard gap between owners.
// Optional BUSY timeout with sticky arb_err: define QSPI_ARB_TIMEOUT_EN.
module qspi_bus_arbiter #(
  parameter int NUM_CH         = 2,
  parameter int GUARD_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_CH-1:0]     ch_req,
  output logic [NUM_CH-1:0]     ch_gnt,
  input  logic [NUM_CH-1:0]     ch_ce_n,
  input  logic [NUM_CH-1:0]     ch_sclk,
  input  logic [4*NUM_CH-1:0]   ch_sio_o,
  input  logic [4*NUM_CH-1:0]   ch_sio_oe,
  output logic [3:0]            ch_sio_i,
  output logic [NUM_CH-1:0]     pad_ce_n,
  output logic                  pad_sclk,
  output logic [3:0]            pad_sio_o,
  output logic [3:0]            pad_sio_oe,
  input  logic [3:0]            pad_sio_i,
  output logic                  arb_err
);

  localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, GUARD} state_t;

  state_t             state_q, state_d;
  logic [3:0]         guard_q, guard_d;
  logic [PTR_W-1:0]   last_q, last_d;
  logic [NUM_CH-1:0]  gnt_d, ce_d;
  logic               sclk_d;
  logic [3:0]         sio_d, oe_d;
  logic [NUM_CH-1:0]  req_eff;
  logic               sel_found;
  logic [PTR_W-1:0]   sel_idx;
  logic [PTR_W:0]     cand;
  logic               release_bus;

  logic [3:0] sio_arr [NUM_CH];
  logic [3:0] oe_arr  [NUM_CH];

  for (genvar k = 0; k < NUM_CH; k++) begin : g_unpack
    assign sio_arr[k] = ch_sio_o[4*k+3:4*k];
    assign oe_arr[k]  = ch_sio_oe[4*k+3:4*k];
  end

`ifdef QSPI_ARB_TIMEOUT_EN
  logic [15:0]       busy_q, busy_d;
  logic              err_q, err_d;
  logic [NUM_CH-1:0] blocked_q, blocked_d;

  // A channel cut off by timeout stays masked until it drops its request once.
  assign req_eff = ch_req & ~blocked_q;
  assign arb_err = err_q;
`else
  assign req_eff = ch_req;
  assign arb_err = 1'b0;
`endif

  // Search upward from the channel after the last owner, wrapping at NUM_CH.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = last_q;
    cand      = '0;
    for (int unsigned i = 1; i <= NUM_CH; i++) begin
      cand = {1'b0, last_q} + (PTR_W+1)'(i);
      if (cand >= (PTR_W+1)'(NUM_CH))
        cand = cand - (PTR_W+1)'(NUM_CH);
      if (!sel_found && req_eff[cand[PTR_W-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = cand[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    guard_d     = guard_q;
    last_d      = last_q;
    gnt_d       = '0;
    ce_d        = '1;
    sclk_d      = 1'b0;
    sio_d       = '0;
    oe_d        = '0;
    release_bus = 1'b0;
`ifdef QSPI_ARB_TIMEOUT_EN
    busy_d      = busy_q;
    err_d       = err_q;
    blocked_d   = blocked_q & ch_req;
`endif
    case (state_q)
      IDLE: begin
        if (sel_found) begin
          state_d        = BUSY;
          last_d         = sel_idx;
          gnt_d[sel_idx] = 1'b1;
`ifdef QSPI_ARB_TIMEOUT_EN
          busy_d         = '0;
`endif
        end
      end
      BUSY: begin
        release_bus = !ch_req[last_q];
`ifdef QSPI_ARB_TIMEOUT_EN
        if (ch_req[last_q] && busy_q == 16'(TIMEOUT_CYCLES - 1)) begin
          release_bus       = 1'b1;
          err_d             = 1'b1;
          blocked_d[last_q] = 1'b1;
        end
`endif
        if (!release_bus) begin
          gnt_d[last_q] = 1'b1;
          ce_d[last_q]  = ch_ce_n[last_q];
          sclk_d        = ch_sclk[last_q];
          sio_d         = sio_arr[last_q];
          oe_d          = oe_arr[last_q];
`ifdef QSPI_ARB_TIMEOUT_EN
          busy_d        = busy_q + 16'd1;
`endif
        end else if (GUARD_CYCLES == 0) begin
          state_d = IDLE;
        end else begin
          state_d = GUARD;
          guard_d = 4'(GUARD_CYCLES - 1);
        end
      end
      GUARD: begin
        if (guard_q == '0)
          state_d = IDLE;
        else
          guard_d = guard_q - 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      guard_q    <= '0;
      last_q     <= PTR_W'(NUM_CH - 1);
      ch_gnt     <= '0;
      pad_ce_n   <= '1;
      pad_sclk   <= 1'b0;
      pad_sio_o  <= '0;
      pad_sio_oe <= '0;
      ch_sio_i   <= '0;
`ifdef QSPI_ARB_TIMEOUT_EN
      busy_q     <= '0;
      err_q      <= 1'b0;
      blocked_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      guard_q    <= guard_d;
      last_q     <= last_d;
      ch_gnt     <= gnt_d;
      pad_ce_n   <= ce_d;
      pad_sclk   <= sclk_d;
      pad_sio_o  <= sio_d;
      pad_sio_oe <= oe_d;
      ch_sio_i   <= pad_sio_i;
`ifdef QSPI_ARB_TIMEOUT_EN
      busy_q     <= busy_d;
      err_q      <= err_d;
      blocked_q  <= blocked_d;
`endif
    end
  end

endmodule

// File: tb/tb_qspi_bus_arbiter.sv
// Directed bench for qspi_bus_arbiter: reset, grant/pad latency, guard gap, input path, round-robin, timeout.
module tb_qspi_bus_arbiter;

  localparam int NUM_CH = 2;
`ifdef QSPI_ARB_TIMEOUT_EN
  localparam int RR_HOLD = 5;
`else
  localparam int RR_HOLD = 10;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [NUM_CH-1:0] ch_req, ch_gnt, ch_ce_n, ch_sclk, pad_ce_n;
  logic [4*NUM_CH-1:0] ch_sio_o, ch_sio_oe;
  logic [3:0]        ch_sio_i, pad_sio_o, pad_sio_oe, pad_sio_i;
  logic              pad_sclk, arb_err;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  qspi_bus_arbiter #(
    .NUM_CH(NUM_CH),
    .GUARD_CYCLES(3),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst(rst),
    .ch_req(ch_req), .ch_gnt(ch_gnt),
    .ch_ce_n(ch_ce_n), .ch_sclk(ch_sclk),
    .ch_sio_o(ch_sio_o), .ch_sio_oe(ch_sio_oe), .ch_sio_i(ch_sio_i),
    .pad_ce_n(pad_ce_n), .pad_sclk(pad_sclk),
    .pad_sio_o(pad_sio_o), .pad_sio_oe(pad_sio_oe), .pad_sio_i(pad_sio_i),
    .arb_err(arb_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_safe(input string tag);
    check({tag, "_ce"},   32'(pad_ce_n),   32'h3);
    check({tag, "_sclk"}, 32'(pad_sclk),   32'h0);
    check({tag, "_oe"},   32'(pad_sio_oe), 32'h0);
    check({tag, "_gnt"},  32'(ch_gnt),     32'h0);
  endtask

  initial begin
    int w;
    int unsigned order [4];
    order = '{0, 1, 0, 1};

    // Reset with random channel activity
    rst       = 1'b1;
    ch_req    = NUM_CH'($urandom);
    ch_ce_n   = NUM_CH'($urandom);
    ch_sclk   = NUM_CH'($urandom);
    ch_sio_o  = 8'($urandom);
    ch_sio_oe = 8'($urandom);
    pad_sio_i = 4'($urandom);
    tick();
    tick();
    check_safe("rst");
    check("rst_sio_o", 32'(pad_sio_o), 32'h0);
    check("rst_sio_i", 32'(ch_sio_i),  32'h0);
    check("rst_err",   32'(arb_err),   32'h0);

    rst    = 1'b0;
    ch_req = '0;
    pad_sio_i = 4'h5;
    tick();
    check_safe("idle");
    check("in_idle", 32'(ch_sio_i), 32'h5);

    // Single grant to ch1; ch0 drives conflicting values that must be ignored
    ch_req    = 2'b10;
    ch_ce_n   = 2'b00;
    ch_sclk   = 2'b11;
    ch_sio_o  = 8'hA5;
    ch_sio_oe = 8'hF3;
    tick();
    check("g1_gnt", 32'(ch_gnt),   32'h2);
    check("g1_ce0", 32'(pad_ce_n), 32'h3);
    tick();
    check("g1_pce",  32'(pad_ce_n),   32'h1);
    check("g1_sclk", 32'(pad_sclk),   32'h1);
    check("g1_sio",  32'(pad_sio_o),  32'hA);
    check("g1_oe",   32'(pad_sio_oe), 32'hF);

    ch_sio_o  = 8'h35;
    pad_sio_i = 4'h9;
    tick();
    check("g1_sio2", 32'(pad_sio_o), 32'h3);
    check("in_busy", 32'(ch_sio_i),  32'h9);

    // ch1 releases with ch0 waiting: guard of 3, grant at release+5
    ch_req    = 2'b01;
    pad_sio_i = 4'hC;
    tick();
    check("in_guard", 32'(ch_sio_i), 32'hC);
    check_safe("gd1");
    for (int k = 2; k <= 4; k++) begin
      tick();
      check_safe($sformatf("gd%0d", k));
    end
    tick();
    check("gd_regrant", 32'(ch_gnt), 32'h1);

    // Reset in the middle of a ch0 transaction
    ch_ce_n = 2'b00;
    tick();
    check("mid_ce", 32'(pad_ce_n), 32'h2);
    rst = 1'b1;
    tick();
    check_safe("mid_rst");
    rst    = 1'b0;
    ch_req = 2'b11;

    // Round-robin with both requests held
    for (int k = 0; k < 4; k++) begin
      w = 0;
      while (ch_gnt == '0 && w < 20) begin
        tick();
        w++;
      end
      check($sformatf("rr%0d_gnt", k), 32'(ch_gnt), 32'h1 << order[k]);
      if (k > 0)
        check($sformatf("rr%0d_wait", k), 32'(w), 32'd4);
      repeat (RR_HOLD) tick();
      ch_req[order[k]] = 1'b0;
      tick();
      ch_req[order[k]] = 1'b1;
    end

`ifdef QSPI_ARB_TIMEOUT_EN
    ch_req = '0;
    rst    = 1'b1;
    tick();
    rst    = 1'b0;
    ch_req = 2'b01;
    tick();
    check("to_gnt0", 32'(ch_gnt), 32'h1);
    ch_req = 2'b11;
    repeat (7) tick();
    check("to_hold", 32'(ch_gnt), 32'h1);
    tick();
    check("to_drop", 32'(ch_gnt),  32'h0);
    check("to_err",  32'(arb_err), 32'h1);
    repeat (4) tick();
    check("to_gnt1", 32'(ch_gnt), 32'h2);
    tick();
    ch_req = 2'b01;
    repeat (8) tick();
    check("to_blocked", 32'(ch_gnt), 32'h0);
    ch_req = 2'b00;
    tick();
    ch_req = 2'b01;
    w = 0;
    while (ch_gnt == '0 && w < 10) begin
      tick();
      w++;
    end
    check("to_regrant", 32'(ch_gnt),  32'h1);
    check("to_sticky",  32'(arb_err), 32'h1);
`else
    check("err_tied", 32'(arb_err), 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
